// File: rtl/vga_timing_generator.sv
// VGA raster timing generator.
// It divides the system clock down to the pixel rate and counts columns and
// rows over the full line/frame, including porches and sync. From the next
// count values it decodes registered sync, active and strobe outputs.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-high
//   enable        in   1 = run, 0 = freeze divider, counters and decode
//   pixel_tick    out  high in each clock where the counters advance
//   column_count  out  current column, 0..H_TOTAL-1
//   row_count     out  current row, 0..V_TOTAL-1
//   hsync/vsync   out  registered syncs, level HSYNC_POL/VSYNC_POL in window
//   video_active  out  column < H_ACTIVE and row < V_ACTIVE
//   line_start    out  one-clock strobe on the first clock of column 0
//   frame_start   out  one-clock strobe on the first clock of (0,0)
module vga_timing_generator #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned PIXEL_DIV   = 1,
  parameter int unsigned COUNT_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   pixel_tick,
  output logic [COUNT_WIDTH-1:0] column_count,
  output logic [COUNT_WIDTH-1:0] row_count,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   video_active,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned CW      = COUNT_WIDTH;
  localparam int unsigned DIV_W   = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);
  localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0]    V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0]    HS_BEG   = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0]    HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0]    VS_BEG   = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0]    VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    col_q, col_d;
  logic [CW-1:0]    row_q, row_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             release_q;   // set during reset, consumed on the first free clock
  logic             tick;

  // Divider, counters and decode of the next count values
  always_comb begin
    tick     = enable && (div_q == DIV_LAST);
    div_d    = div_q;
    col_d    = col_q;
    row_d    = row_q;

    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    if (tick) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    hsync_d  = ((col_d >= HS_BEG) && (col_d < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d  = ((row_d >= VS_BEG) && (row_d < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    active_d = (col_d < H_ACT_C) && (row_d < V_ACT_C);

    // A column of 0 after a tick can only come from a wrap
    line_d   = release_q || (tick && (col_d == '0));
    frame_d  = release_q || (tick && (col_d == '0) && (row_d == '0));
  end

  // State registers; reset takes priority over enable
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      active_q  <= 1'b1;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      release_q <= 1'b1;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      row_q     <= row_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      release_q <= 1'b0;
    end
  end

  // The tick marks the clock whose edge advances the counters; masked in reset
  assign pixel_tick   = tick && !reset;
  assign column_count = col_q;
  assign row_count    = row_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_active = active_q;
  assign line_start   = line_q;
  assign frame_start  = frame_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three instances share clock, reset and
// enable (defaults, PIXEL_DIV=4, and a small active-high-sync raster).
module tb_vga_timing_generator;

  typedef struct {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    bit hp; bit vp; int div;
  } cfg_t;

  typedef struct {
    int div; int col; int row;
    bit hsy; bit vsy; bit act; bit ls; bit fs; bit pend;
  } mdl_t;

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic hs; logic vs; logic va; logic ls; logic fs;
  } exp_t;

  typedef struct { exp_t a; exp_t q; exp_t s; } sb_t;

  typedef struct {
    bit r; int e; int n;
    int col; int row; bit hs; bit va; bit ls; bit fs;
  } vec_t;

  localparam cfg_t CA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1};
  localparam cfg_t CQ = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 4};
  localparam cfg_t CS = '{16, 2, 4, 3, 8, 1, 2, 2, 1'b1, 1'b1, 1};

  logic clock, reset, enable;
  logic       a_pt, a_hs, a_vs, a_va, a_ls, a_fs;
  logic [9:0] a_col, a_row;
  logic       q_pt, q_hs, q_vs, q_va, q_ls, q_fs;
  logic [9:0] q_col, q_row;
  logic       s_pt, s_hs, s_vs, s_va, s_ls, s_fs;
  logic [4:0] s_col, s_row;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int q_ticks = 0;
  mdl_t ma, mq, ms;
  sb_t sbq[$];
  vec_t tbl[12];

  vga_timing_generator u_a (
    .clock(clock), .reset(reset), .enable(enable), .pixel_tick(a_pt),
    .column_count(a_col), .row_count(a_row), .hsync(a_hs), .vsync(a_vs),
    .video_active(a_va), .line_start(a_ls), .frame_start(a_fs));

  vga_timing_generator #(.PIXEL_DIV(4)) u_q (
    .clock(clock), .reset(reset), .enable(enable), .pixel_tick(q_pt),
    .column_count(q_col), .row_count(q_row), .hsync(q_hs), .vsync(q_vs),
    .video_active(q_va), .line_start(q_ls), .frame_start(q_fs));

  vga_timing_generator #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIXEL_DIV(1), .COUNT_WIDTH(5)
  ) u_s (
    .clock(clock), .reset(reset), .enable(enable), .pixel_tick(s_pt),
    .column_count(s_col), .row_count(s_row), .hsync(s_hs), .vsync(s_vs),
    .video_active(s_va), .line_start(s_ls), .frame_start(s_fs));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference raster model, one system clock per call
  function automatic bit mtick(cfg_t c, mdl_t m, bit r, bit e);
    return !r && e && (m.div == c.div - 1);
  endfunction

  function automatic mdl_t mstep(cfg_t c, mdl_t m, bit r, bit e);
    mdl_t n = m;
    int htot = c.ha + c.hf + c.hsw + c.hb;
    int vtot = c.va + c.vf + c.vsw + c.vb;
    if (r) begin
      n.div = 0; n.col = 0; n.row = 0;
      n.hsy = !c.hp; n.vsy = !c.vp; n.act = 1'b1;
      n.ls = 1'b0; n.fs = 1'b0; n.pend = 1'b1;
      return n;
    end
    n.ls = m.pend; n.fs = m.pend; n.pend = 1'b0;
    if (e) n.div = (m.div + 1) % c.div;
    if (mtick(c, m, r, e)) begin
      n.col = (m.col + 1) % htot;
      if (n.col == 0) begin
        n.row = (m.row + 1) % vtot;
        n.ls = 1'b1;
        if (n.row == 0) n.fs = 1'b1;
      end
    end
    n.hsy = (n.col >= c.ha + c.hf && n.col < c.ha + c.hf + c.hsw) ? c.hp : !c.hp;
    n.vsy = (n.row >= c.va + c.vf && n.row < c.va + c.vf + c.vsw) ? c.vp : !c.vp;
    n.act = (n.col < c.ha) && (n.row < c.va);
    return n;
  endfunction

  function automatic exp_t mexp(mdl_t m);
    exp_t x;
    x.col = 16'(m.col); x.row = 16'(m.row);
    x.hs = m.hsy; x.vs = m.vsy; x.va = m.act; x.ls = m.ls; x.fs = m.fs;
    return x;
  endfunction

  task automatic chk_exp(input string nm, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got col=%0d row=%0d hs=%0b vs=%0b va=%0b ls=%0b fs=%0b want col=%0d row=%0d hs=%0b vs=%0b va=%0b ls=%0b fs=%0b",
               nm, cyc, got.col, got.row, got.hs, got.vs, got.va, got.ls, got.fs,
               want.col, want.row, want.hs, want.vs, want.va, want.ls, want.fs);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, got, want);
    end
  endtask

  // One clock: check the tick, push the expected post-edge state, pop and compare
  task automatic cycle(input bit r, input bit e);
    sb_t x, w;
    reset = r; enable = e;
    #1;
    chk_int("tick_a", int'(a_pt), int'(mtick(CA, ma, r, e)));
    chk_int("tick_q", int'(q_pt), int'(mtick(CQ, mq, r, e)));
    chk_int("tick_s", int'(s_pt), int'(mtick(CS, ms, r, e)));
    if (q_pt) q_ticks++;
    ma = mstep(CA, ma, r, e);
    mq = mstep(CQ, mq, r, e);
    ms = mstep(CS, ms, r, e);
    w.a = mexp(ma); w.q = mexp(mq); w.s = mexp(ms);
    sbq.push_back(w);
    @(posedge clock);
    @(negedge clock);
    w = sbq.pop_front();
    x.a = '{16'(a_col), 16'(a_row), a_hs, a_vs, a_va, a_ls, a_fs};
    x.q = '{16'(q_col), 16'(q_row), q_hs, q_vs, q_va, q_ls, q_fs};
    x.s = '{16'(s_col), 16'(s_row), s_hs, s_vs, s_va, s_ls, s_fs};
    chk_exp("out_a", x.a, w.a);
    chk_exp("out_q", x.q, w.q);
    chk_exp("out_s", x.s, w.s);
    cyc++;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return a_ls;
      1:       return q_ls;
      2:       return s_fs;
      3:       return (s_col == 5'd20) && (s_row == 5'd10);
      default: return s_col == 5'd18;
    endcase
  endfunction

  // Run enabled clocks until the selected event; an expired bound is a failure
  task automatic wait_for(input string nm, input int sel, input int bound,
                          output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      cycle(1'b0, 1'b1);
      if (cond(sel)) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout after %0d clocks", nm, bound);
    end
  endtask

  initial begin
    int t0, t1, k;
    bit ok0, ok1;

    // r, e (2 = random), clocks, then expected default-instance state
    tbl[0]  = '{1'b1, 0, 1,   0,   0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2, 2,   0,   0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1, 1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1, 299, 300, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 0, 37,  300, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1, 1,   301, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1, 339, 640, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1, 16,  656, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1, 95,  751, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1, 1,   752, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1, 47,  799, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1, 1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b0};

    ma = '{default: 0}; mq = '{default: 0}; ms = '{default: 0};
    reset = 1'b1; enable = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        if (tbl[v].e == 2) cycle(tbl[v].r, 1'($urandom_range(0, 1)));
        else               cycle(tbl[v].r, tbl[v].e != 0);
      end
      chk_int($sformatf("vec%0d_col", v), int'(a_col), tbl[v].col);
      chk_int($sformatf("vec%0d_row", v), int'(a_row), tbl[v].row);
      chk_int($sformatf("vec%0d_hs", v),  int'(a_hs),  int'(tbl[v].hs));
      chk_int($sformatf("vec%0d_va", v),  int'(a_va),  int'(tbl[v].va));
      chk_int($sformatf("vec%0d_ls", v),  int'(a_ls),  int'(tbl[v].ls));
      chk_int($sformatf("vec%0d_fs", v),  int'(a_fs),  int'(tbl[v].fs));
      if (v == 1) chk_int("rst_vsync", int'(a_vs), 1);
    end

    // Default line period, starting from the line_start just observed
    t0 = cyc;
    wait_for("a_line", 0, 1000, t1, ok1);
    if (ok1) chk_int("a_line_period", t1 - t0, 800);

    // Divide-by-4: one tick in four clocks, 3200-clock lines
    k = q_ticks;
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1);
    chk_int("q_tick_count", q_ticks - k, 10);
    wait_for("q_line0", 1, 3300, t0, ok0);
    wait_for("q_line1", 1, 3300, t1, ok1);
    if (ok0 && ok1) chk_int("q_line_period", t1 - t0, 3200);

    // Small raster: full frame length
    wait_for("s_frame0", 2, 400, t0, ok0);
    wait_for("s_frame1", 2, 400, t1, ok1);
    if (ok0 && ok1) chk_int("s_frame_period", t1 - t0, 325);

    // Reset while inside both sync windows of the small raster
    wait_for("s_at_20_10", 3, 400, t0, ok0);
    cycle(1'b1, 1'b1);
    chk_int("s_rst_col", int'(s_col), 0);
    chk_int("s_rst_row", int'(s_row), 0);
    chk_int("s_rst_hs",  int'(s_hs), 0);
    chk_int("s_rst_vs",  int'(s_vs), 0);
    chk_int("s_rst_va",  int'(s_va), 1);
    cycle(1'b0, 1'b1);
    chk_int("s_rel_fs", int'(s_fs), 1);
    chk_int("s_rel_ls", int'(s_ls), 1);
    wait_for("s_col18", 4, 30, t0, ok0);
    if (ok0) chk_int("s_hs_active_high", int'(s_hs), 1);
    cycle(1'b0, 1'b1);
    chk_int("s_ls_one_shot", int'(s_ls), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Parametrised VGA raster timing generator. It replaces the fixed 640x480 active-area sync block with full porch/sync/back-porch timing, programmable sync polarity, an internal pixel-clock divider, a pause input, and line/frame start strobes. It sits between the system clock and the pixel/paddle/ball renderers. Its counts and `video_active` drive pixel generation, and `hsync`/`vsync` go directly to the VGA connector.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible columns
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible rows
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `HSYNC_POL`, 0, level of `hsync` during the sync window (0 = active-low)
- `VSYNC_POL`, 0, level of `vsync` during the sync window (0 = active-low)
- `PIXEL_DIV`, 1, system clocks per pixel (1..16)
- `COUNT_WIDTH`, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- `clock`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  1 = run; 0 = freeze the divider and counters
- `pixel_tick`  out  1  1 on each clock in which the counters advance
- `column_count`  out  COUNT_WIDTH  current column, 0..H_TOTAL-1
- `row_count`  out  COUNT_WIDTH  current row, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, registered, polarity per `HSYNC_POL`
- `vsync`  out  1  vertical sync, registered, polarity per `VSYNC_POL`
- `video_active`  out  1  1 when column < H_ACTIVE and row < V_ACTIVE
- `line_start`  out  1  one-clock strobe: first clock with column 0
- `frame_start`  out  1  one-clock strobe: first clock with column 0 and row 0

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800)
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (default 525)
- Divider:
  - `div_count` (0..PIXEL_DIV-1) increments on every clock with `enable`=1, wrapping at PIXEL_DIV-1.
  - `pixel_tick` = `enable` && `div_count`==PIXEL_DIV-1.
  - With PIXEL_DIV=1, `pixel_tick` = `enable`.
- Counters, on `pixel_tick`:
  - column increments; at H_TOTAL-1 it wraps to 0 and row increments.
  - row wraps from V_TOTAL-1 to 0.
  - Between ticks, both counters hold.
- Decode:
  - Horizontal sync window: H_ACTIVE+H_FRONT <= column < H_ACTIVE+H_FRONT+H_SYNC (default 656..751).
  - Vertical sync window: V_ACTIVE+V_FRONT <= row < V_ACTIVE+V_FRONT+V_SYNC (default 490..491).
  - Inside the window, sync = POL; outside, sync = ~POL.
- Registered decode: `hsync`, `vsync` and `video_active` are registers loaded from the next count values. They always describe the `column_count`/`row_count` presented in the same cycle, with zero skew.
- Strobes:
  - `line_start` asserts for exactly one clock, in the cycle after the column wraps to 0.
  - `frame_start` asserts likewise when both counters wrap to (0,0).
  - Both also assert for one clock in the first cycle after `reset` deasserts, independent of `enable`.
- Freeze: while `enable`=0, the divider, counters and sync/active registers hold, and `pixel_tick` is 0. Strobes do not re-assert when `enable` returns.
- Width rule: counter arithmetic wraps by explicit compare only, never by overflow. Widths smaller than needed are a configuration error.

## Timing
- Reset values:
  - `div_count`=0, `column_count`=0, `row_count`=0
  - `hsync`=~HSYNC_POL, `vsync`=~VSYNC_POL
  - `video_active`=1, because (0,0) is visible
  - `pixel_tick`=0, `line_start`=0, `frame_start`=0
- Reset mid-frame: on the clock after `reset` is sampled high, all outputs hold their reset values. Reset overrides `enable`.
- Latency: a counter change and its sync/active decode appear on the same clock edge.
- Wrap sequence (defaults, PIXEL_DIV=1): (799,524) -> (0,0). The cycle presenting (0,0) has `frame_start`=1, `line_start`=1, `video_active`=1.
- Frame length: H_TOTAL*V_TOTAL*PIXEL_DIV enabled clocks. The default is 420000.

## Test plan
- Reset: hold `reset` 3 clocks with random `enable` -> counts 0, `hsync`=`vsync`=1, `video_active`=1, `pixel_tick`=0. The next clock after release gives `frame_start`=`line_start`=1.
- Horizontal timing, defaults: `hsync` falls in the cycle presenting column 656 and rises at 752. `video_active` falls at column 640 and rises at 0. `line_start` has a period of 800 clocks.
- Vertical wrap: run a full frame -> `vsync` low only on rows 490-491. Row 524 -> 0 coincides with `frame_start`. The next `frame_start` comes exactly 420000 clocks later.
- PIXEL_DIV=4 -> `pixel_tick` every 4th clock. Each column value held 4 clocks. `line_start` period 3200.
- `enable` low for 37 clocks mid-line at column 300 -> counts and syncs frozen, `pixel_tick`=0. Counting resumes at 301 with no skipped column.
- `reset` asserted at (700,491) with HSYNC_POL=VSYNC_POL=1 -> the next cycle shows (0,0), `hsync`=`vsync`=0. Sync pulses are then active-high.
